// File: rtl/mips_debug_pkg.sv
// Shared types and constants for the MIPS debug controller.
// Optional feature macro used by this slice: MIPS_DEBUG_CHECKSUM_EN.
package mips_debug_pkg;

  // Controller states; ST_DUMP_CSUM is reachable only with the checksum trailer.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_CNT,
    ST_LOAD_WORD,
    ST_LOAD_WR,
    ST_ACK,
    ST_NAK,
    ST_RUN,
    ST_STEP,
    ST_STEP_WAIT,
    ST_DUMP_PC,
    ST_DUMP_REG,
    ST_DUMP_MEM,
    ST_DUMP_CSUM
  } state_e;

  // Per-word progress inside a dump or reply phase.
  typedef enum logic [1:0] {
    PH_FETCH,   // read address driven, data arrives next cycle
    PH_LOAD,    // hand the word to the serialiser
    PH_SEND     // wait for the serialiser to finish
  } phase_e;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_DUMP = 8'h44;  // 'D'
  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  // Number of UART bytes that make up one pipeline word.
  function automatic int bytes_per_word(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/mips_debug_word_tx.sv
// Word-to-byte serialiser with a ready/valid TX handshake.
// Sends a word MSB byte first, or only its MSB byte when single_i is set.
// A byte is presented, held until accepted, then the line idles one cycle.
module mips_debug_word_tx
  import mips_debug_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  single_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  tx_ready_i,
  output logic [BYTE_WIDTH-1:0] tx_byte_o,
  output logic                  tx_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BPW = bytes_per_word(DATA_WIDTH, BYTE_WIDTH);
  localparam int CW  = $clog2(BPW + 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  fire;

  assign fire       = valid_q && tx_ready_i;
  assign tx_byte_o  = shift_q[DATA_WIDTH-1 -: BYTE_WIDTH];
  assign tx_valid_o = valid_q;
  assign busy_o     = (cnt_q != '0);
  assign done_o     = done_q;

  // Next-state: accept a new word when idle, otherwise advance on each transfer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (cnt_q == '0) begin
      if (load_i) begin
        shift_d = word_i;
        cnt_d   = single_i ? CW'(1) : CW'(BPW);
        valid_d = 1'b1;
      end
    end else if (fire) begin
      shift_d = shift_q << BYTE_WIDTH;
      cnt_d   = cnt_q - 1'b1;
      valid_d = 1'b0;
      done_d  = (cnt_q == CW'(1));
    end else if (!valid_q) begin
      valid_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/mips_debug_ctrl.sv
// MIPS debug controller: decodes the UART command stream, loads IMEM,
// drives run/step and streams PC, register and memory snapshots back.
// Optional: define MIPS_DEBUG_CHECKSUM_EN to append an XOR byte to each dump.
module mips_debug_ctrl
  import mips_debug_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_REGS   = 32,
  parameter int MEM_WORDS  = 32,
  parameter int IMEM_DEPTH = 256
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [BYTE_WIDTH-1:0]        i_rx_byte,
  input  logic                         i_rx_valid,
  output logic [BYTE_WIDTH-1:0]        o_tx_byte,
  output logic                         o_tx_valid,
  input  logic                         i_tx_ready,
  input  logic                         i_finish,
  input  logic [DATA_WIDTH-1:0]        i_pc,
  output logic [$clog2(NUM_REGS)-1:0]  o_reg_addr,
  input  logic [DATA_WIDTH-1:0]        i_reg_data,
  output logic [$clog2(MEM_WORDS)-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0]        i_mem_data,
  output logic [DATA_WIDTH-1:0]        o_instruccion,
  output logic [DATA_WIDTH-1:0]        o_address,
  output logic                         o_loading,
  output logic                         o_start,
  output logic                         o_step,
  output logic                         o_reg_send,
  output logic                         o_mem_send
);

  localparam int BPW = bytes_per_word(DATA_WIDTH, BYTE_WIDTH);
  localparam int RAW = $clog2(NUM_REGS);
  localparam int MAW = $clog2(MEM_WORDS);
  localparam int AW  = (RAW > MAW) ? RAW : MAW;
  localparam int IW  = $clog2(IMEM_DEPTH + 1);
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [AW-1:0]  REG_LAST  = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0]  MEM_LAST  = AW'(MEM_WORDS - 1);
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BPW - 1);

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [AW-1:0]         addr_q, addr_d;     // register / memory dump address
  logic [IW-1:0]         idx_q, idx_d;       // words already written to IMEM
  logic [IW-1:0]         num_q, num_d;       // words announced by the load command
  logic [BCW-1:0]        bcnt_q, bcnt_d;     // bytes received of the current word
  logic [DATA_WIDTH-1:0] asm_q, asm_d;       // word being assembled from RX bytes

  logic                  tx_load, tx_single, tx_busy, tx_done;
  logic [DATA_WIDTH-1:0] tx_word;
  logic                  rx_bad_count;

  // Places a single reply byte in the MSB lane so the serialiser sends it first.
  function automatic logic [DATA_WIDTH-1:0] msb_byte(input logic [BYTE_WIDTH-1:0] b);
    return DATA_WIDTH'(b) << (DATA_WIDTH - BYTE_WIDTH);
  endfunction

  // A word count of zero, or more words than IMEM holds, is refused.
  assign rx_bad_count = (i_rx_byte == '0) ||
                        ({1'b0, i_rx_byte} > (BYTE_WIDTH + 1)'(IMEM_DEPTH));

`ifdef MIPS_DEBUG_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] csum_q, csum_d;

  // Running XOR of every byte transferred from the PC word to the last memory byte.
  always_comb begin
    csum_d = csum_q;
    if (state_q inside {ST_DUMP_PC, ST_DUMP_REG, ST_DUMP_MEM}) begin
      if (o_tx_valid && i_tx_ready) csum_d = csum_q ^ o_tx_byte;
    end else if (state_q != ST_DUMP_CSUM) begin
      csum_d = '0;
    end
  end

  // Checksum register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) csum_q <= '0;
    else          csum_q <= csum_d;
  end
`endif

  // Command decode, load sequencing, run/step control and dump sequencing.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    num_d     = num_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    tx_load   = 1'b0;
    tx_single = 1'b0;
    tx_word   = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          phase_d = PH_LOAD;
          if      (i_rx_byte == BYTE_WIDTH'(CMD_LOAD)) state_d = ST_LOAD_CNT;
          else if (i_rx_byte == BYTE_WIDTH'(CMD_RUN))  state_d = ST_RUN;
          else if (i_rx_byte == BYTE_WIDTH'(CMD_STEP)) state_d = ST_STEP;
          else if (i_rx_byte == BYTE_WIDTH'(CMD_DUMP)) state_d = ST_DUMP_PC;
          else                                         state_d = ST_NAK;
        end
      end

      ST_LOAD_CNT: begin
        if (i_rx_valid) begin
          if (rx_bad_count) begin
            state_d = ST_NAK;
            phase_d = PH_LOAD;
          end else begin
            num_d   = IW'(i_rx_byte);
            idx_d   = '0;
            bcnt_d  = '0;
            state_d = ST_LOAD_WORD;
          end
        end
      end

      ST_LOAD_WORD: begin
        if (i_rx_valid) begin
          asm_d = (asm_q << BYTE_WIDTH) | DATA_WIDTH'(i_rx_byte);
          if (bcnt_q == BYTE_LAST) begin
            bcnt_d  = '0;
            state_d = ST_LOAD_WR;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end

      // o_loading is high in this state; the index moves on afterwards.
      ST_LOAD_WR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == num_q - 1'b1) begin
          state_d = ST_ACK;
          phase_d = PH_LOAD;
        end else begin
          state_d = ST_LOAD_WORD;
        end
      end

      ST_ACK, ST_NAK: begin
        tx_single = 1'b1;
        tx_word   = msb_byte((state_q == ST_ACK) ? BYTE_WIDTH'(ACK_BYTE) : BYTE_WIDTH'(NAK_BYTE));
        if (phase_q == PH_LOAD) begin
          if (!tx_busy) begin
            tx_load = 1'b1;
            phase_d = PH_SEND;
          end
        end else if (tx_done) begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (i_finish) begin
          state_d = ST_DUMP_PC;
          phase_d = PH_LOAD;
        end
      end

      ST_STEP: state_d = ST_STEP_WAIT;

      ST_STEP_WAIT: begin
        state_d = ST_DUMP_PC;
        phase_d = PH_LOAD;
      end

      ST_DUMP_PC: begin
        tx_word = i_pc;
        if (phase_q == PH_LOAD) begin
          if (!tx_busy) begin
            tx_load = 1'b1;
            phase_d = PH_SEND;
          end
        end else if (tx_done) begin
          addr_d  = '0;
          phase_d = PH_FETCH;
          state_d = ST_DUMP_REG;
        end
      end

      ST_DUMP_REG: begin
        tx_word = i_reg_data;
        case (phase_q)
          PH_FETCH: phase_d = PH_LOAD;
          PH_LOAD: begin
            if (!tx_busy) begin
              tx_load = 1'b1;
              phase_d = PH_SEND;
            end
          end
          default: begin
            if (tx_done) begin
              phase_d = PH_FETCH;
              if (addr_q == REG_LAST) begin
                addr_d  = '0;
                state_d = ST_DUMP_MEM;
              end else begin
                addr_d = addr_q + 1'b1;
              end
            end
          end
        endcase
      end

      ST_DUMP_MEM: begin
        tx_word = i_mem_data;
        case (phase_q)
          PH_FETCH: phase_d = PH_LOAD;
          PH_LOAD: begin
            if (!tx_busy) begin
              tx_load = 1'b1;
              phase_d = PH_SEND;
            end
          end
          default: begin
            if (tx_done) begin
              if (addr_q == MEM_LAST) begin
                addr_d  = '0;
                phase_d = PH_LOAD;
`ifdef MIPS_DEBUG_CHECKSUM_EN
                state_d = ST_DUMP_CSUM;
`else
                state_d = ST_IDLE;
`endif
              end else begin
                addr_d  = addr_q + 1'b1;
                phase_d = PH_FETCH;
              end
            end
          end
        endcase
      end

`ifdef MIPS_DEBUG_CHECKSUM_EN
      ST_DUMP_CSUM: begin
        tx_single = 1'b1;
        tx_word   = msb_byte(csum_q);
        if (phase_q == PH_LOAD) begin
          if (!tx_busy) begin
            tx_load = 1'b1;
            phase_d = PH_SEND;
          end
        end else if (tx_done) begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers; reset aborts any transfer in flight.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      phase_q <= PH_FETCH;
      addr_q  <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
    end
  end

  // Shared serialiser for PC, register, memory words and single reply bytes.
  mips_debug_word_tx #(
    .DATA_WIDTH (DATA_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_word_tx (
    .clk_i      (i_clock),
    .rst_ni     (i_reset),
    .load_i     (tx_load),
    .single_i   (tx_single),
    .word_i     (tx_word),
    .tx_ready_i (i_tx_ready),
    .tx_byte_o  (o_tx_byte),
    .tx_valid_o (o_tx_valid),
    .busy_o     (tx_busy),
    .done_o     (tx_done)
  );

  assign o_start       = (state_q == ST_RUN);
  assign o_step        = (state_q == ST_STEP);
  assign o_reg_send    = (state_q == ST_DUMP_REG);
  assign o_mem_send    = (state_q == ST_DUMP_MEM);
  assign o_loading     = (state_q == ST_LOAD_WR);
  assign o_instruccion = o_loading ? asm_q : '0;
  assign o_address     = o_loading ? DATA_WIDTH'(idx_q) * DATA_WIDTH'(BPW) : '0;
  assign o_reg_addr    = o_reg_send ? addr_q[RAW-1:0] : '0;
  assign o_mem_addr    = o_mem_send ? addr_q[MAW-1:0] : '0;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Directed bench for mips_debug_ctrl (DATA_WIDTH=32, NUM_REGS=4, MEM_WORDS=2).
// Honours MIPS_DEBUG_CHECKSUM_EN when expecting the dump trailer.
module tb_mips_debug_ctrl;

  localparam int DW = 32;
  localparam int BW = 8;
  localparam int NR = 4;
  localparam int MW = 2;
  localparam int ID = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [BW-1:0] rx_byte = '0;
  logic          rx_valid = 1'b0;
  logic          tx_ready = 1'b1;
  logic          finish = 1'b0;
  logic [DW-1:0] pc = '0;
  logic [DW-1:0] reg_data = '0;
  logic [DW-1:0] mem_data = '0;

  logic [BW-1:0] tx_byte;
  logic          tx_valid;
  logic [1:0]    reg_addr;
  logic [0:0]    mem_addr;
  logic [DW-1:0] instr, iaddr;
  logic          loading, start, step, reg_send, mem_send;

  logic [DW-1:0] regs [NR];
  logic [DW-1:0] mems [MW];

  logic [7:0]    tx_q [$];
  logic [7:0]    exp_q [$];
  logic [63:0]   load_q [$];
  int            step_cnt = 0;
  int            hold_err = 0;
  logic          hold_q = 1'b0;
  logic [7:0]    hold_byte = '0;

  int            tests = 0;
  int            fails = 0;

  mips_debug_ctrl #(
    .DATA_WIDTH (DW),
    .BYTE_WIDTH (BW),
    .NUM_REGS   (NR),
    .MEM_WORDS  (MW),
    .IMEM_DEPTH (ID)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_rx_byte     (rx_byte),
    .i_rx_valid    (rx_valid),
    .o_tx_byte     (tx_byte),
    .o_tx_valid    (tx_valid),
    .i_tx_ready    (tx_ready),
    .i_finish      (finish),
    .i_pc          (pc),
    .o_reg_addr    (reg_addr),
    .i_reg_data    (reg_data),
    .o_mem_addr    (mem_addr),
    .i_mem_data    (mem_data),
    .o_instruccion (instr),
    .o_address     (iaddr),
    .o_loading     (loading),
    .o_start       (start),
    .o_step        (step),
    .o_reg_send    (reg_send),
    .o_mem_send    (mem_send)
  );

  always #5 clk = ~clk;

  // Register file and data memory with one-cycle read latency.
  always @(posedge clk) begin
    reg_data <= regs[reg_addr];
    mem_data <= mems[mem_addr];
  end

  // Monitor sampled 1 time unit after the falling edge, well away from the active edge.
  always @(negedge clk) begin
    #1;
    if (hold_q && (!tx_valid || tx_byte !== hold_byte)) hold_err++;
    hold_q    = tx_valid && !tx_ready && rst_n;
    hold_byte = tx_byte;
    if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
    if (loading) load_q.push_back({instr, iaddr});
    if (step) step_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int cyc;
    cyc = 0;
    while (tx_q.size() < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (tx_q.size() < n) check("tx_timeout", tx_q.size(), n);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
  endtask

  // Expected dump: PC, every register, every memory word, optional XOR trailer.
  task automatic build_dump(input logic [31:0] pcv);
    exp_q.delete();
    push_word(pcv);
    for (int r = 0; r < NR; r++) push_word(regs[r]);
    for (int m = 0; m < MW; m++) push_word(mems[m]);
`ifdef MIPS_DEBUG_CHECKSUM_EN
    begin : add_csum
      logic [7:0] x;
      x = '0;
      foreach (exp_q[i]) x ^= exp_q[i];
      exp_q.push_back(x);
    end
`endif
  endtask

  task automatic compare_tx(input string tag);
    logic [63:0] got;
    wait_tx(exp_q.size());
    idle(8);
    check({tag, "_len"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < tx_q.size()) ? 64'(tx_q[i]) : 64'h100;
      check($sformatf("%s_b%0d", tag, i), got, exp_q[i]);
    end
  endtask

  logic [7:0] t3 [28] = '{8'h00, 8'h00, 8'h00, 8'h08,
                          8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                          8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03,
                          8'h00, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00, 8'hF1};

  initial begin
    int hi;
    logic [63:0] got;
    for (int r = 0; r < NR; r++) regs[r] = DW'(r);
    mems[0] = 32'h0000_00F0;
    mems[1] = 32'h0000_00F1;

    // Reset state
    #2 rst_n = 1'b0;
    idle(3);
    #1 check("rst_outputs", |{tx_byte, tx_valid, reg_addr, mem_addr, instr, iaddr,
                                loading, start, step, reg_send, mem_send}, 0);
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    #1 check("idle_outputs", |{tx_valid, loading, start, step, reg_send, mem_send}, 0);

    // 1: load two words
    send_byte(8'h4C); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    exp_q.delete(); exp_q.push_back(8'hA5);
    compare_tx("ack");
    check("load_cnt", load_q.size(), 2);
    got = (load_q.size() > 0) ? load_q[0] : '1;
    check("load0", got, 64'h12345678_00000000);
    got = (load_q.size() > 1) ? load_q[1] : '1;
    check("load1", got, 64'hAABBCCDD_00000004);

    // 2: zero word count and an unknown command
    tx_q.delete();
    send_byte(8'h4C); send_byte(8'h00);
    exp_q.delete(); exp_q.push_back(8'hEE);
    compare_tx("nak_zero");
    tx_q.delete();
    send_byte(8'h58);
    compare_tx("nak_cmd");

    // 3: single step with hand-computed dump
    tx_q.delete();
    pc = 32'h8;
    step_cnt = 0;
    send_byte(8'h53);
    exp_q.delete();
    foreach (t3[i]) exp_q.push_back(t3[i]);
`ifdef MIPS_DEBUG_CHECKSUM_EN
    exp_q.push_back(8'h09);
`endif
    compare_tx("step");
    check("step_pulses", step_cnt, 1);

    // 4: run until finish, an RX byte mid-run is ignored
    tx_q.delete();
    pc = 32'h0040_0010;
    send_byte(8'h52);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      rx_byte  = 8'h4C;
      rx_valid = (i == 10);
      #1 if (start) hi++;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check("run_start_hi", hi, 20);
    finish = 1'b1;
    #1 check("start_at_finish", start, 1);
    @(negedge clk) finish = 1'b0;
    #1 check("start_after_finish", start, 0);
    build_dump(pc);
    compare_tx("run");
    check("run_no_load", load_q.size(), 2);

    // 5: back-pressure mid-dump
    tx_q.delete();
    pc = 32'h1234_5678;
    regs[2] = 32'hDEAD_BEEF;
    send_byte(8'h44);
    wait_tx(10);
    tx_ready = 1'b0;
    idle(10);
    tx_ready = 1'b1;
    build_dump(pc);
    compare_tx("stall");
    check("stall_hold_err", hold_err, 0);

    // 6: reset during the register phase, then a clean dump
    tx_q.delete();
    send_byte(8'h44);
    wait_tx(8);
    #3 rst_n = 1'b0;
    #1 check("midreset_outputs", |{tx_byte, tx_valid, reg_addr, mem_addr, instr, iaddr,
                                     loading, start, step, reg_send, mem_send}, 0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    tx_q.delete();
    pc = 32'h0000_0ABC;
    send_byte(8'h44);
    build_dump(pc);
    compare_tx("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
